// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I control unit.
// The optional trap state is compiled in with MC_CTRL_TRAP_EN.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_IL = 7'b0000011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_U  = 7'b0110111;
  localparam logic [6:0] OP_UL = 7'b0010111;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_JL = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [2:0] WB_ALU      = 3'd0;
  localparam logic [2:0] WB_DMEM     = 3'd1;
  localparam logic [2:0] WB_IMM      = 3'd2;
  localparam logic [2:0] WB_IMM_BASE = 3'd3;
  localparam logic [2:0] WB_PC4      = 3'd4;

  typedef struct packed {
    logic       reg_wr;
    logic       pc_adv;
    logic       alu_src;
    logic [2:0] wb_sel;
    logic [3:0] alu;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       is_load;
    logic       is_store;
    logic       legal;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational opcode/funct decoder; produces the EXECUTE-state control
// bits, which the FSM in multicycle_ctrl gates by state.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output ctrl_t      o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_R: begin
        o_ctrl.reg_wr = 1'b1;
        o_ctrl.pc_adv = 1'b1;
        o_ctrl.alu    = {i_funct7_5, i_funct3};
        o_ctrl.legal  = 1'b1;
      end
      OP_I: begin
        o_ctrl.reg_wr  = 1'b1;
        o_ctrl.pc_adv  = 1'b1;
        o_ctrl.alu_src = 1'b1;
        // Only the shift-right pair uses funct7[5]; other immediates own that bit.
        o_ctrl.alu     = {(i_funct3 == 3'b101) ? i_funct7_5 : 1'b0, i_funct3};
        o_ctrl.legal   = 1'b1;
      end
      OP_IL: begin
        o_ctrl.alu_src = 1'b1;
        o_ctrl.alu     = ALU_ADD;
        o_ctrl.is_load = 1'b1;
        o_ctrl.legal   = 1'b1;
      end
      OP_S: begin
        o_ctrl.alu_src  = 1'b1;
        o_ctrl.alu      = ALU_ADD;
        o_ctrl.is_store = 1'b1;
        o_ctrl.legal    = 1'b1;
      end
      OP_B: begin
        o_ctrl.branch = 1'b1;
        o_ctrl.pc_adv = 1'b1;
        o_ctrl.alu    = {1'b0, i_funct3};
        o_ctrl.legal  = 1'b1;
      end
      OP_U: begin
        o_ctrl.reg_wr = 1'b1;
        o_ctrl.pc_adv = 1'b1;
        o_ctrl.wb_sel = WB_IMM;
        o_ctrl.legal  = 1'b1;
      end
      OP_UL: begin
        o_ctrl.reg_wr = 1'b1;
        o_ctrl.pc_adv = 1'b1;
        o_ctrl.wb_sel = WB_IMM_BASE;
        o_ctrl.legal  = 1'b1;
      end
      OP_J: begin
        o_ctrl.reg_wr = 1'b1;
        o_ctrl.pc_adv = 1'b1;
        o_ctrl.wb_sel = WB_PC4;
        o_ctrl.jal    = 1'b1;
        o_ctrl.legal  = 1'b1;
      end
      OP_JL: begin
        // The ALU forms the jump target rs1+imm.
        o_ctrl.reg_wr  = 1'b1;
        o_ctrl.pc_adv  = 1'b1;
        o_ctrl.alu_src = 1'b1;
        o_ctrl.alu     = ALU_ADD;
        o_ctrl.wb_sel  = WB_PC4;
        o_ctrl.jalr    = 1'b1;
        o_ctrl.legal   = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WB, instruction
// register and retired-instruction counter. MC_CTRL_TRAP_EN adds TRAP.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_rdata,
  input  logic        i_ready,
  output logic        i_req,
  input  logic        d_ready,
  output logic        d_req,
  output logic        d_we,
  input  logic        btaken,
  output logic [31:0] instr_code,
  output logic        pc_en,
  output logic        reg_wr_en,
  output logic        aluSrcMux,
  output logic [2:0]  regwdataSel,
  output logic [3:0]  alu_controls,
  output logic        branch,
  output logic        JAL,
  output logic        JARL,
  output logic [31:0] instret,
  output state_t      o_dbg_state
`ifdef MC_CTRL_TRAP_EN
  ,
  output logic        illegal_instr
`endif
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_instr;
  logic [31:0] r_instret;
  ctrl_t       w_ctrl;
  logic        w_unused;

  // Branch resolution happens in the PC mux; the controller only enables the PC.
  assign w_unused = btaken;

  mc_ctrl_decode u_decode (
    .i_opcode   (r_instr[6:0]),
    .i_funct3   (r_instr[14:12]),
    .i_funct7_5 (r_instr[30]),
    .o_ctrl     (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH:   if (i_ready) w_next_state = ST_DECODE;
      ST_DECODE:  w_next_state = ST_EXECUTE;
      ST_EXECUTE: begin
        if (w_ctrl.is_load || w_ctrl.is_store) w_next_state = ST_MEM;
`ifdef MC_CTRL_TRAP_EN
        else if (!w_ctrl.legal)                w_next_state = ST_TRAP;
`endif
        else                                   w_next_state = ST_FETCH;
      end
      ST_MEM:     if (d_ready) w_next_state = w_ctrl.is_load ? ST_WB : ST_FETCH;
      ST_WB:      w_next_state = ST_FETCH;
`ifdef MC_CTRL_TRAP_EN
      ST_TRAP:    w_next_state = ST_TRAP;
`endif
      default:    w_next_state = ST_FETCH;
    endcase
  end

  // Every output is forced low while reset is high so an aborted instruction
  // cannot write the register file or advance the PC in the reset cycle.
  always_comb begin
    i_req        = 1'b0;
    d_req        = 1'b0;
    d_we         = 1'b0;
    pc_en        = 1'b0;
    reg_wr_en    = 1'b0;
    aluSrcMux    = 1'b0;
    regwdataSel  = WB_ALU;
    alu_controls = ALU_ADD;
    branch       = 1'b0;
    JAL          = 1'b0;
    JARL         = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_FETCH: i_req = 1'b1;
        ST_EXECUTE: begin
`ifdef MC_CTRL_TRAP_EN
          pc_en = w_ctrl.pc_adv;
`else
          pc_en = w_ctrl.pc_adv | ~w_ctrl.legal;
`endif
          reg_wr_en    = w_ctrl.reg_wr;
          aluSrcMux    = w_ctrl.alu_src;
          regwdataSel  = w_ctrl.wb_sel;
          alu_controls = w_ctrl.alu;
          branch       = w_ctrl.branch;
          JAL          = w_ctrl.jal;
          JARL         = w_ctrl.jalr;
        end
        ST_MEM: begin
          d_req = 1'b1;
          d_we  = w_ctrl.is_store;
          pc_en = w_ctrl.is_store & d_ready;
        end
        ST_WB: begin
          regwdataSel = WB_DMEM;
          reg_wr_en   = 1'b1;
          pc_en       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                             r_instr <= '0;
    else if (r_state == ST_FETCH && i_ready) r_instr <= i_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset)      r_instret <= '0;
    else if (pc_en) r_instret <= r_instret + 32'd1;
  end

`ifdef MC_CTRL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk) begin
    if (reset)                        r_illegal <= 1'b0;
    else if (w_next_state == ST_TRAP) r_illegal <= 1'b1;
  end
  assign illegal_instr = r_illegal & ~reset;
`endif

  assign instr_code  = r_instr;
  assign instret     = r_instret;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl; exercises the trap path when
// compiled with MC_CTRL_TRAP_EN, the NOP path otherwise.
module tb_multicycle_ctrl;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        i_req;
  logic        d_ready;
  logic        d_req;
  logic        d_we;
  logic        btaken;
  logic [31:0] instr_code;
  logic        pc_en;
  logic        reg_wr_en;
  logic        aluSrcMux;
  logic [2:0]  regwdataSel;
  logic [3:0]  alu_controls;
  logic        branch;
  logic        JAL;
  logic        JARL;
  logic [31:0] instret;
  state_t      o_dbg_state;
`ifdef MC_CTRL_TRAP_EN
  logic        illegal_instr;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [19:0] exp_q[$];
  logic [31:0] exp_instret;

  multicycle_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_rdata      (i_rdata),
    .i_ready      (i_ready),
    .i_req        (i_req),
    .d_ready      (d_ready),
    .d_req        (d_req),
    .d_we         (d_we),
    .btaken       (btaken),
    .instr_code   (instr_code),
    .pc_en        (pc_en),
    .reg_wr_en    (reg_wr_en),
    .aluSrcMux    (aluSrcMux),
    .regwdataSel  (regwdataSel),
    .alu_controls (alu_controls),
    .branch       (branch),
    .JAL          (JAL),
    .JARL         (JARL),
    .instret      (instret),
    .o_dbg_state  (o_dbg_state)
`ifdef MC_CTRL_TRAP_EN
    ,
    .illegal_instr(illegal_instr)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Retire-cycle snapshot: {reg_wr_en, regwdataSel, aluSrcMux, alu_controls, branch, JAL, JARL, latency}
  function automatic logic [19:0] mk_exp(input logic wr, input logic [2:0] sel, input logic src,
                                         input logic [3:0] alu, input logic br, input logic j,
                                         input logic jr, input int lat);
    logic [7:0] l;
    l = lat[7:0];
    return {wr, sel, src, alu, br, j, jr, l};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b1;
    i_ready = 1'b0;
    d_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_instret = '0;
  endtask

  // Driver: serves one instruction with the given wait counts, then scores it at retirement.
  task automatic run_instr(input string tag, input logic [31:0] instr, input int iw, input int dw,
                           input logic [19:0] exp, output int n_dreq, output int n_dwe,
                           output int n_wr);
    int icnt = 0;
    int dcnt = 0;
    int cyc = 0;
    bit done = 0;
    logic [7:0] c8;
    logic [19:0] got;
    logic [19:0] want;
    n_dreq = 0;
    n_dwe  = 0;
    n_wr   = 0;
    exp_q.push_back(exp);
    while (!done && cyc < 60) begin
      @(negedge clk);
      cyc++;
      i_rdata = instr;
      i_ready = i_req && (icnt >= iw);
      if (i_req) icnt++;
      d_ready = d_req && (dcnt >= dw);
      if (d_req) dcnt++;
      #1;
      if (d_req) n_dreq++;
      if (d_we) n_dwe++;
      if (reg_wr_en) n_wr++;
      if (pc_en) begin
        c8 = cyc[7:0];
        got = {reg_wr_en, regwdataSel, aluSrcMux, alu_controls, branch, JAL, JARL, c8};
        want = exp_q.pop_front();
        check({tag, "_retire"}, 32'(got), 32'(want));
        exp_instret = exp_instret + 32'd1;
        done = 1;
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'(cyc), 32'd0);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    check({tag, "_instret"}, instret, exp_instret);
  endtask

  initial begin
    int nd, nw, nr, cnt, ireq_trap;
    logic [31:0] r;
    reset   = 1'b1;
    i_rdata = '0;
    i_ready = 1'b0;
    d_ready = 1'b0;
    btaken  = 1'b0;
    exp_instret = '0;

    repeat (2) @(negedge clk);
    #1;
    check("rst_state", 32'(o_dbg_state), 32'(ST_FETCH));
    check("rst_instr", instr_code, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_ireq", 32'(i_req), 32'd0);
    check("rst_pcen", 32'(pc_en), 32'd0);
`ifdef MC_CTRL_TRAP_EN
    check("rst_illegal", 32'(illegal_instr), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    run_instr("add", 32'h002081B3, 0, 0, mk_exp(1, 3'd0, 0, 4'b0000, 0, 0, 0, 3), nd, nw, nr);
    check("add_ir", instr_code, 32'h002081B3);
    run_instr("sub_iwait", 32'h402081B3, 2, 0, mk_exp(1, 3'd0, 0, 4'b1000, 0, 0, 0, 5), nd, nw, nr);

    run_instr("lw", 32'h0040A283, 0, 2, mk_exp(1, 3'd1, 0, 4'b0000, 0, 0, 0, 7), nd, nw, nr);
    check("lw_dreq_cycles", 32'(nd), 32'd3);
    check("lw_no_dwe", 32'(nw), 32'd0);
    check("lw_wr_once", 32'(nr), 32'd1);

    run_instr("sw", 32'h0020A023, 0, 0, mk_exp(0, 3'd0, 0, 4'b0000, 0, 0, 0, 4), nd, nw, nr);
    check("sw_dwe", 32'(nw), 32'd1);
    check("sw_dreq", 32'(nd), 32'd1);
    check("sw_no_wr", 32'(nr), 32'd0);

    run_instr("beq", 32'h00208463, 0, 0, mk_exp(0, 3'd0, 0, 4'b0000, 1, 0, 0, 3), nd, nw, nr);
    run_instr("srai", 32'h4030D293, 0, 0, mk_exp(1, 3'd0, 1, 4'b1101, 0, 0, 0, 3), nd, nw, nr);
    run_instr("andi_neg", 32'hFFF0F193, 0, 0, mk_exp(1, 3'd0, 1, 4'b0111, 0, 0, 0, 3), nd, nw, nr);
    run_instr("slti", 32'h0050A193, 0, 0, mk_exp(1, 3'd0, 1, 4'b0010, 0, 0, 0, 3), nd, nw, nr);
    run_instr("lui", 32'h123452B7, 0, 0, mk_exp(1, 3'd2, 0, 4'b0000, 0, 0, 0, 3), nd, nw, nr);
    run_instr("auipc", 32'h00001297, 0, 0, mk_exp(1, 3'd3, 0, 4'b0000, 0, 0, 0, 3), nd, nw, nr);
    run_instr("jal", 32'h008000EF, 0, 0, mk_exp(1, 3'd4, 0, 4'b0000, 0, 1, 0, 3), nd, nw, nr);
    run_instr("jalr", 32'h000100E7, 0, 0, mk_exp(1, 3'd4, 1, 4'b0000, 0, 0, 1, 3), nd, nw, nr);

    // Random wait states on a load/store mix
    for (int k = 0; k < 4; k++) begin
      int iw, dw;
      iw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      if (k[0])
        run_instr("rnd_sw", 32'h0020A023, iw, dw,
                  mk_exp(0, 3'd0, 0, 4'b0000, 0, 0, 0, 4 + iw + dw), nd, nw, nr);
      else
        run_instr("rnd_lw", 32'h0040A283, iw, dw,
                  mk_exp(1, 3'd1, 0, 4'b0000, 0, 0, 0, 5 + iw + dw), nd, nw, nr);
      check("rnd_dreq_cycles", 32'(nd), 32'(dw + 1));
    end

    // Reset while waiting in MEM
    cnt = 0;
    while (o_dbg_state != ST_MEM && cnt < 20) begin
      @(negedge clk);
      cnt++;
      i_rdata = 32'h0040A283;
      i_ready = i_req;
      d_ready = 1'b0;
    end
    check("mem_reached", 32'(o_dbg_state), 32'(ST_MEM));
    reset   = 1'b1;
    d_ready = 1'b1;
    i_ready = 1'b0;
    #1;
    check("rst_mid_pcen", 32'(pc_en), 32'd0);
    check("rst_mid_wr", 32'(reg_wr_en), 32'd0);
    check("rst_mid_dreq", 32'(d_req), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    d_ready = 1'b0;
    exp_instret = '0;
    #1;
    check("rst_mid_state", 32'(o_dbg_state), 32'(ST_FETCH));
    check("rst_mid_ir", instr_code, 32'd0);
    check("rst_mid_instret", instret, 32'd0);
    check("rst_mid_ireq", 32'(i_req), 32'd1);

`ifdef MC_CTRL_TRAP_EN
    ireq_trap = 0;
    nr = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      i_rdata = 32'h0000007F;
      i_ready = i_req;
      #1;
      if (o_dbg_state == ST_TRAP && i_req) ireq_trap++;
      if (pc_en || reg_wr_en) nr++;
    end
    check("trap_state", 32'(o_dbg_state), 32'(ST_TRAP));
    check("trap_illegal", 32'(illegal_instr), 32'd1);
    check("trap_no_ireq", 32'(ireq_trap), 32'd0);
    check("trap_no_enables", 32'(nr), 32'd0);
    check("trap_instret", instret, 32'd0);
    do_reset();
    #1;
    check("trap_cleared", 32'(illegal_instr), 32'd0);
`else
    run_instr("nop_unknown", 32'h0000007F, 0, 0, mk_exp(0, 3'd0, 0, 4'b0000, 0, 0, 0, 3), nd, nw, nr);
    check("nop_no_wr", 32'(nr), 32'd0);
`endif

    // Counter wrap
    @(negedge clk);
    i_ready = 1'b0;
    force dut.r_instret = 32'hFFFFFFFF;
    @(negedge clk);
    release dut.r_instret;
    #1;
    r = instret;
    check("wrap_preload", r, 32'hFFFFFFFF);
    exp_instret = 32'hFFFFFFFF;
    run_instr("wrap_add", 32'h002081B3, 0, 0, mk_exp(1, 3'd0, 0, 4'b0000, 0, 0, 0, 3), nd, nw, nr);
    check("wrap_zero", instret, 32'd0);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
